// File: rtl/mips_mem_pkg.sv
// ---------------------------------------------------------------------------
// mips_mem_pkg
// Shared definitions for the instruction/data BRAM port arbiter of the
// multi-cycle MIPS core: default memory geometry, the arbiter FSM state
// encoding and the access-owner encoding.
// Ports: none (package).
// ---------------------------------------------------------------------------
package mips_mem_pkg;

  // Default BRAM geometry: 1024 words of 32 bits.
  localparam int ADDR_W_DEF = 10;
  localparam int DATA_W_DEF = 32;

  // Arbiter sequencing states.
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_RESP  = 2'd3
  } arb_state_t;

  // Requester that currently owns the memory port.
  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_CPU  = 2'd1,
    OWN_DBG  = 2'd2
  } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve_counter.sv
// ---------------------------------------------------------------------------
// starve_counter
// Saturating count of cycles the debug requester has waited without a grant.
// Once the count reaches MAX, hit stays high until clr.
// Ports:
//   clk  in   clock, rising edge
//   rst  in   asynchronous active-high reset (count -> 0)
//   inc  in   count one more starved cycle
//   clr  in   clear the count (has priority over inc)
//   hit  out  count has reached MAX
// ---------------------------------------------------------------------------
module starve_counter #(
  parameter int MAX = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic inc,
  input  logic clr,
  output logic hit
);

  localparam logic [7:0] MAX_C = 8'(MAX);

  logic [7:0] count_r;

  // Starvation count register, saturating at MAX.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count_r <= 8'd0;
    end else if (clr) begin
      count_r <= 8'd0;
    end else if (inc && (count_r != MAX_C)) begin
      count_r <= count_r + 8'd1;
    end else begin
      count_r <= count_r;
    end
  end

  assign hit = (count_r == MAX_C);

endmodule

// File: rtl/mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// mem_port_arbiter
// Shares the single-port instruction/data BRAM between the CPU datapath
// (fetch and load/store) and the debug inference readout. Accesses are
// serialised by an IDLE -> ISSUE -> (WAIT -> RESP) sequence; all outputs are
// registered. CPU has fixed priority over debug.
//
// Build option: define DBG_STARVE_GUARD_EN to add a starvation guard that
// lets debug win arbitration after STARVE_MAX denied cycles.
//
// Ports:
//   fast_clk, rst                       clock / async active-high reset
//   cpu_req, cpu_we, cpu_addr, cpu_wdata CPU request (held until cpu_gnt)
//   cpu_gnt, cpu_rvalid, cpu_rdata      CPU grant pulse, read data + valid
//   dbg_req, dbg_addr                   debug read request (held until dbg_gnt)
//   dbg_gnt, dbg_rvalid, dbg_rdata      debug grant pulse, read data + valid
//   mem_en, mem_we, mem_addr, mem_wdata BRAM command
//   mem_rdata                           BRAM read data (one cycle after mem_en)
// ---------------------------------------------------------------------------
module mem_port_arbiter
  import mips_mem_pkg::*;
#(
  parameter int ADDR_W     = ADDR_W_DEF,
  parameter int DATA_W     = DATA_W_DEF,
  parameter int STARVE_MAX = 15
) (
  input  logic              fast_clk,
  input  logic              rst,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic              cpu_gnt,
  output logic              cpu_rvalid,
  output logic [DATA_W-1:0] cpu_rdata,
  input  logic              dbg_req,
  input  logic [ADDR_W-1:0] dbg_addr,
  output logic              dbg_gnt,
  output logic              dbg_rvalid,
  output logic [DATA_W-1:0] dbg_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  // Reject an out-of-range guard threshold at elaboration.
  if ((STARVE_MAX < 1) || (STARVE_MAX > 255)) begin : g_bad_starve_max
    $error("mem_port_arbiter: STARVE_MAX must be in 1..255");
  end

  arb_state_t state_r;
  owner_t     owner_r;
  logic       starve_hit_s;
  logic       dbg_wins_s;

`ifdef DBG_STARVE_GUARD_EN
  starve_counter #(
    .MAX (STARVE_MAX)
  ) u_starve_counter (
    .clk (fast_clk),
    .rst (rst),
    .inc (dbg_req & ~dbg_gnt),
    .clr (dbg_gnt),
    .hit (starve_hit_s)
  );
`else
  assign starve_hit_s = 1'b0;
`endif

  // Arbitration: debug wins only if CPU is idle or debug has been starved.
  always_comb begin
    dbg_wins_s = 1'b0;
    if (dbg_req && (!cpu_req || starve_hit_s)) begin
      dbg_wins_s = 1'b1;
    end else begin
      dbg_wins_s = 1'b0;
    end
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge fast_clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      owner_r    <= OWN_NONE;
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      cpu_rdata  <= {DATA_W{1'b0}};
      dbg_rdata  <= {DATA_W{1'b0}};
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= {ADDR_W{1'b0}};
      mem_wdata  <= {DATA_W{1'b0}};
    end else begin
      // Pulse outputs default low; the command address/data hold their value.
      cpu_gnt    <= 1'b0;
      dbg_gnt    <= 1'b0;
      cpu_rvalid <= 1'b0;
      dbg_rvalid <= 1'b0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      case (state_r)
        ST_IDLE: begin
          if (cpu_req || dbg_req) begin
            state_r <= ST_ISSUE;
            mem_en  <= 1'b1;
            if (dbg_wins_s) begin
              owner_r   <= OWN_DBG;
              dbg_gnt   <= 1'b1;
              mem_we    <= 1'b0;
              mem_addr  <= dbg_addr;
              mem_wdata <= {DATA_W{1'b0}};
            end else begin
              owner_r   <= OWN_CPU;
              cpu_gnt   <= 1'b1;
              mem_we    <= cpu_we;
              mem_addr  <= cpu_addr;
              mem_wdata <= cpu_wdata;
            end
          end else begin
            state_r <= ST_IDLE;
          end
        end
        ST_ISSUE: begin
          // mem_we still holds the command issued this cycle.
          if (mem_we) begin
            state_r <= ST_IDLE;
            owner_r <= OWN_NONE;
          end else begin
            state_r <= ST_WAIT;
          end
        end
        ST_WAIT: begin
          state_r <= ST_RESP;
          if (owner_r == OWN_DBG) begin
            dbg_rdata  <= mem_rdata;
            dbg_rvalid <= 1'b1;
          end else if (owner_r == OWN_CPU) begin
            cpu_rdata  <= mem_rdata;
            cpu_rvalid <= 1'b1;
          end else begin
            cpu_rdata <= cpu_rdata;
          end
        end
        ST_RESP: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
        end
        default: begin
          state_r <= ST_IDLE;
          owner_r <= OWN_NONE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// ---------------------------------------------------------------------------
// tb_mem_port_arbiter
// Directed stimulus pushes expected grant/read-valid events (with the cycle
// they must appear in) into a scoreboard queue; an independent monitor pops
// and compares whenever the DUT pulses a gnt or rvalid. A behavioural BRAM
// model sits on the mem_* port.
// ---------------------------------------------------------------------------
module tb_mem_port_arbiter;

  localparam int AW = 10;
  localparam int DW = 32;

  logic          fast_clk = 1'b0;
  logic          rst = 1'b1;
  logic          cpu_req = 1'b0, cpu_we = 1'b0;
  logic [AW-1:0] cpu_addr = '0;
  logic [DW-1:0] cpu_wdata = '0;
  logic          cpu_gnt, cpu_rvalid;
  logic [DW-1:0] cpu_rdata;
  logic          dbg_req = 1'b0;
  logic [AW-1:0] dbg_addr = '0;
  logic          dbg_gnt, dbg_rvalid;
  logic [DW-1:0] dbg_rdata;
  logic          mem_en, mem_we;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata;
  logic [DW-1:0] mem_rdata = '0;

  mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(15)) dut (
    .fast_clk(fast_clk), .rst(rst),
    .cpu_req(cpu_req), .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_gnt(cpu_gnt), .cpu_rvalid(cpu_rvalid), .cpu_rdata(cpu_rdata),
    .dbg_req(dbg_req), .dbg_addr(dbg_addr),
    .dbg_gnt(dbg_gnt), .dbg_rvalid(dbg_rvalid), .dbg_rdata(dbg_rdata),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  always #5 fast_clk = ~fast_clk;

  // Cycle number of the clock period following each rising edge.
  int cyc = 0;
  always @(posedge fast_clk) cyc <= cyc + 1;

  // Behavioural single-port BRAM, one-cycle read latency.
  logic [DW-1:0] bram [0:1023];
  always @(posedge fast_clk) begin
    if (mem_en) begin
      if (mem_we) bram[mem_addr] <= mem_wdata;
      else        mem_rdata <= bram[mem_addr];
    end
  end

  // Event kinds: 0 cpu_gnt, 1 dbg_gnt, 2 cpu_rvalid, 3 dbg_rvalid.
  typedef struct {
    int            kind;
    int            cyc;
    logic [AW-1:0] addr;
    logic          we;
    logic [DW-1:0] data;
  } ev_t;

  ev_t sb_q[$];
  int  n_cmp = 0;
  int  n_err = 0;
  bit  sb_en = 1'b1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic push(input int kind, input int c, input logic [AW-1:0] a,
                      input logic we, input logic [DW-1:0] d);
    ev_t e;
    e.kind = kind; e.cyc = c; e.addr = a; e.we = we; e.data = d;
    sb_q.push_back(e);
  endtask

  task automatic sb_pop(input int kind);
    ev_t e;
    if (sb_q.size() == 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL unexpected_event: kind %0d at cycle %0d, expected no event", kind, cyc);
    end else begin
      e = sb_q.pop_front();
      check($sformatf("event_kind_k%0d", kind), 64'(kind), 64'(e.kind));
      check($sformatf("event_cycle_k%0d", kind), 64'(cyc), 64'(e.cyc));
      if (kind < 2) begin
        check("gnt_mem_addr", 64'(mem_addr), 64'(e.addr));
        check("gnt_mem_we", 64'(mem_we), 64'(e.we));
        if (e.we) check("gnt_mem_wdata", 64'(mem_wdata), 64'(e.data));
      end else if (kind == 2) begin
        check("cpu_rdata", 64'(cpu_rdata), 64'(e.data));
      end else begin
        check("dbg_rdata", 64'(dbg_rdata), 64'(e.data));
      end
    end
  endtask

  // Monitor: sample away from the active edge and score every pulse.
  always @(negedge fast_clk) begin
    if (!rst) begin
      if (cpu_gnt || dbg_gnt)
        check("gnt_exclusive", 64'(cpu_gnt & dbg_gnt), 64'd0);
      if (cpu_rvalid || dbg_rvalid)
        check("rvalid_exclusive", 64'(cpu_rvalid & dbg_rvalid), 64'd0);
      if (mem_en || cpu_gnt || dbg_gnt)
        check("mem_en_with_gnt", 64'(mem_en), 64'(cpu_gnt | dbg_gnt));
      if (sb_en) begin
        if (cpu_gnt)    sb_pop(0);
        if (dbg_gnt)    sb_pop(1);
        if (cpu_rvalid) sb_pop(2);
        if (dbg_rvalid) sb_pop(3);
      end
    end
  end

  task automatic wait_gnt(input bit dbg, output int at);
    at = -1;
    for (int i = 0; i < 20; i++) begin
      @(negedge fast_clk);
      if (dbg ? dbg_gnt : cpu_gnt) begin
        at = cyc;
        break;
      end
    end
    if (at < 0) begin
      n_cmp++;
      n_err++;
      $display("FAIL gnt_timeout: no %s grant within 20 cycles, expected one", dbg ? "dbg" : "cpu");
    end
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_pulses"}, 64'({cpu_gnt, dbg_gnt, cpu_rvalid, dbg_rvalid, mem_en, mem_we}), 64'd0);
    check({tag, "_mem_addr"}, 64'(mem_addr), 64'd0);
    check({tag, "_mem_wdata"}, 64'(mem_wdata), 64'd0);
    check({tag, "_cpu_rdata"}, 64'(cpu_rdata), 64'd0);
    check({tag, "_dbg_rdata"}, 64'(dbg_rdata), 64'd0);
  endtask

  task automatic cpu_read(input logic [AW-1:0] a, input logic [DW-1:0] exp);
    int t, g;
    @(negedge fast_clk);
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = a;
    push(0, t + 1, a, 1'b0, '0);
    push(2, t + 3, '0, 1'b0, exp);
    wait_gnt(1'b0, g);
    cpu_req = 1'b0;
    repeat (4) @(negedge fast_clk);
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int t, g, g2, at;
    bit got;
    for (int i = 0; i < 1024; i++) bram[i] = 32'h0;
    bram[1] = 32'hA5A5_0001;
    bram[5] = 32'hDEAD_BEEF;

    // Reset state.
    repeat (3) @(negedge fast_clk);
    check_zero("reset");
    rst = 1'b0;
    @(negedge fast_clk);
    check_zero("post_reset");

    // CPU read of address 5.
    cpu_read(10'd5, 32'hDEAD_BEEF);

    // CPU write 0x12345678 to 9, with a back-to-back read of 9 queued behind it.
    @(negedge fast_clk);
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b1; cpu_addr = 10'd9; cpu_wdata = 32'h1234_5678;
    push(0, t + 1, 10'd9, 1'b1, 32'h1234_5678);
    wait_gnt(1'b0, g);
    t = cyc;
    cpu_we = 1'b0;
    push(0, t + 2, 10'd9, 1'b0, '0);
    push(2, t + 4, '0, 1'b0, 32'h1234_5678);
    wait_gnt(1'b0, g);
    cpu_req = 1'b0;
    repeat (4) @(negedge fast_clk);

    // Contention: CPU served first, debug four cycles later.
    @(negedge fast_clk);
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd9;
    dbg_req = 1'b1; dbg_addr = 10'd1;
    push(0, t + 1, 10'd9, 1'b0, '0);
    push(2, t + 3, '0, 1'b0, 32'h1234_5678);
    push(1, t + 5, 10'd1, 1'b0, '0);
    push(3, t + 7, '0, 1'b0, 32'hA5A5_0001);
    wait_gnt(1'b0, g);
    cpu_req = 1'b0;
    wait_gnt(1'b1, g2);
    dbg_req = 1'b0;
    repeat (4) @(negedge fast_clk);
    check("dbg_rdata_hold", 64'(dbg_rdata), 64'h0000_0000_A5A5_0001);

    // Starvation: CPU requests continuously, debug waits.
    sb_en = 1'b0;
    @(negedge fast_clk);
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    dbg_req = 1'b1; dbg_addr = 10'd5;
    got = 1'b0;
    at = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge fast_clk);
      if (dbg_gnt) begin
        got = 1'b1;
        at = cyc;
        break;
      end
    end
`ifdef DBG_STARVE_GUARD_EN
    check("starve_dbg_gnt_seen", 64'(got), 64'd1);
    check("starve_dbg_gnt_in_bound", 64'((at - t) <= 19), 64'd1);
`else
    check("strict_prio_no_dbg_gnt", 64'(got), 64'd0);
`endif
    cpu_req = 1'b0;
    dbg_req = 1'b0;
    repeat (8) @(negedge fast_clk);
    sb_en = 1'b1;

    // Reset asserted during the WAIT cycle of a CPU read.
    @(negedge fast_clk);
    t = cyc;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 10'd5;
    push(0, t + 1, 10'd5, 1'b0, '0);
    wait_gnt(1'b0, g);
    cpu_req = 1'b0;
    @(negedge fast_clk);
    rst = 1'b1;
    #1;
    check_zero("mid_read_reset");
    @(negedge fast_clk);
    @(negedge fast_clk);
    rst = 1'b0;
    repeat (4) @(negedge fast_clk);

    // Normal traffic after reset release.
    cpu_read(10'd9, 32'h1234_5678);

    // Debug-only read of address 5.
    @(negedge fast_clk);
    t = cyc;
    dbg_req = 1'b1; dbg_addr = 10'd5;
    push(1, t + 1, 10'd5, 1'b0, '0);
    push(3, t + 3, '0, 1'b0, 32'hDEAD_BEEF);
    wait_gnt(1'b1, g);
    dbg_req = 1'b0;
    repeat (4) @(negedge fast_clk);

    // A CPU read must not disturb the debug read-data register.
    cpu_read(10'd1, 32'hA5A5_0001);
    check("dbg_rdata_after_cpu", 64'(dbg_rdata), 64'h0000_0000_DEAD_BEEF);
    check("cpu_rdata_hold", 64'(cpu_rdata), 64'h0000_0000_A5A5_0001);

    check("scoreboard_drained", 64'(sb_q.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
